// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared state encoding, coin values and price lookup for the vending controller
package vending_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PAY,
    S_VEND,
    S_REFUND
  } state_t;

  localparam int unsigned C1          = 1;
  localparam int unsigned C2          = 2;
  localparam int unsigned PRICE_BUS_W = 256;

  // Price tables are widened to a fixed bus so one helper serves every CREDIT_W.
  function automatic int unsigned price_slice(input logic [PRICE_BUS_W-1:0] prices,
                                              input int unsigned cw,
                                              input int unsigned idx);
    return 32'(prices >> (idx * cw)) & ((32'd1 << cw) - 32'd1);
  endfunction

endpackage

// File: rtl/vend_stock.sv
// rtl/vend_stock.sv - per-item stock counters with saturating restock and vend decrement
module vend_stock
  import vending_pkg::*;
#(
  parameter int                 N_ITEMS    = 4,
  parameter int                 STOCK_W    = 4,
  parameter int                 IW         = 2,
  parameter logic [STOCK_W-1:0] INIT_STOCK = 4'd5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_dec_vld,
  input  logic [IW-1:0]      i_dec_item,
  input  logic               i_rs_vld,
  input  logic [IW-1:0]      i_rs_item,
  input  logic [STOCK_W-1:0] i_rs_qty,
  output logic [N_ITEMS-1:0] o_sold_out
);

  logic [STOCK_W-1:0] r_stock [N_ITEMS];
  logic [STOCK_W:0]   w_sum   [N_ITEMS];

  // One extra bit holds stock+qty-1; a set top bit means the counter saturates.
  always_comb begin
    o_sold_out = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      w_sum[i] = {1'b0, r_stock[i]}
               + ((i_rs_vld && i_rs_item == IW'(i)) ? {1'b0, i_rs_qty} : '0)
               - {{STOCK_W{1'b0}}, (i_dec_vld && i_dec_item == IW'(i))};
      o_sold_out[i] = (r_stock[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ITEMS; i++) begin
      if (!rst) begin
        r_stock[i] <= INIT_STOCK;
      end else begin
        r_stock[i] <= w_sum[i][STOCK_W] ? {STOCK_W{1'b1}} : w_sum[i][STOCK_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vending_machine_param.sv
// rtl/vending_machine_param.sv - parametrised vending FSM with credit, timeout refund and stock tracking
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int                          N_ITEMS    = 4,
  parameter int                          CREDIT_W   = 4,
  parameter int                          STOCK_W    = 4,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter logic [STOCK_W-1:0]          INIT_STOCK = 4'd5,
  parameter int                          TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_ITEMS-1:0]           sel,
  input  logic                         c1,
  input  logic                         c2,
  input  logic                         cnl,
  input  logic                         rs_vld,
  input  logic [$clog2(N_ITEMS)-1:0]   rs_item,
  input  logic [STOCK_W-1:0]           rs_qty,
  output logic                         pdt,
  output logic [$clog2(N_ITEMS)-1:0]   pdt_item,
  output logic [CREDIT_W-1:0]          cng,
  output logic [CREDIT_W-1:0]          rtn,
  output logic [1:0]                   rej,
  output logic                         err,
  output logic [N_ITEMS-1:0]           sold_out,
  output logic                         busy
);

  localparam int                     IW        = $clog2(N_ITEMS);
  localparam int                     TO_W      = $clog2(TIMEOUT);
  localparam int unsigned            LP_CW     = CREDIT_W;
  localparam logic [PRICE_BUS_W-1:0] LP_PRICES = PRICE_BUS_W'(PRICES);

  state_t              r_state, w_next;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt, w_nc, w_price;
  logic [TO_W-1:0]     r_to, w_to_nxt;
  logic [IW-1:0]       r_item, w_item_nxt, w_idx;
  logic                w_onehot;
  logic                r_pdt, r_err, r_busy;
  logic [IW-1:0]       r_pdt_item;
  logic [CREDIT_W-1:0] r_cng, r_rtn;
  logic [1:0]          r_rej;
  logic [N_ITEMS-1:0]  w_sold_out;

  vend_stock #(
    .N_ITEMS   (N_ITEMS),
    .STOCK_W   (STOCK_W),
    .IW        (IW),
    .INIT_STOCK(INIT_STOCK)
  ) u_stock (
    .clk       (clk),
    .rst       (rst),
    .i_dec_vld (r_state == S_VEND),
    .i_dec_item(r_item),
    .i_rs_vld  (rs_vld),
    .i_rs_item (rs_item),
    .i_rs_qty  (rs_qty),
    .o_sold_out(w_sold_out)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel[i]) w_idx = IW'(i);
    end
  end

  assign w_onehot = $onehot(sel);
  assign w_price  = CREDIT_W'(price_slice(LP_PRICES, LP_CW, 32'(r_item)));
  assign w_nc     = r_credit + (c1 ? CREDIT_W'(C1) : '0) + (c2 ? CREDIT_W'(C2) : '0);

  always_comb begin
    w_next       = r_state;
    w_credit_nxt = r_credit;
    w_to_nxt     = r_to;
    w_item_nxt   = r_item;
    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_item_nxt = w_idx;
          w_next     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!w_sold_out[r_item]) begin
          w_credit_nxt = '0;
          w_to_nxt     = '0;
          w_next       = S_PAY;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_PAY: begin
        // Cancel beats a completed payment so coins in the cancel cycle are returned.
        if (cnl || (|sel)) begin
          w_credit_nxt = w_nc;
          w_next       = S_REFUND;
        end else if (w_nc >= w_price) begin
          w_credit_nxt = w_nc;
          w_next       = S_VEND;
        end else if (c1 || c2) begin
          w_credit_nxt = w_nc;
          w_to_nxt     = '0;
        end else if (r_to == TO_W'(TIMEOUT - 1)) begin
          w_next = S_REFUND;
        end else begin
          w_to_nxt = r_to + 1'b1;
        end
      end
      S_VEND:   w_next = S_IDLE;
      S_REFUND: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_to       <= '0;
      r_item     <= '0;
      r_pdt      <= 1'b0;
      r_pdt_item <= '0;
      r_cng      <= '0;
      r_rtn      <= '0;
      r_rej      <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_credit   <= w_credit_nxt;
      r_to       <= w_to_nxt;
      r_item     <= w_item_nxt;
      r_pdt      <= (w_next == S_VEND);
      r_pdt_item <= (w_next == S_VEND) ? r_item : '0;
      r_cng      <= (w_next == S_VEND) ? (w_nc - w_price) : '0;
      r_rtn      <= (w_next == S_REFUND) ? w_credit_nxt : '0;
      r_rej      <= (r_state != S_PAY) ? {c2, c1} : 2'b00;
      r_err      <= (r_state == S_CHECK) && (w_next == S_IDLE);
      r_busy     <= (w_next != S_IDLE);
    end
  end

  assign pdt      = r_pdt;
  assign pdt_item = r_pdt_item;
  assign cng      = r_cng;
  assign rtn      = r_rtn;
  assign rej      = r_rej;
  assign err      = r_err;
  assign busy     = r_busy;
  assign sold_out = w_sold_out;

endmodule

// File: tb/tb_vending_machine_param.sv
// tb/tb_vending_machine_param.sv - scoreboard bench for vending_machine_param with directed vectors
module tb_vending_machine_param;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int SW = 4;
  localparam int IW = 2;

  localparam int EV_PDT = 0;
  localparam int EV_RTN = 1;
  localparam int EV_ERR = 2;
  localparam int EV_REJ = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  sel = '0;
  logic          c1 = 1'b0, c2 = 1'b0, cnl = 1'b0, rs_vld = 1'b0;
  logic [IW-1:0] rs_item = '0;
  logic [SW-1:0] rs_qty = '0;
  logic          pdt, err, busy;
  logic [IW-1:0] pdt_item;
  logic [CW-1:0] cng, rtn;
  logic [1:0]    rej;
  logic [N-1:0]  sold_out;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  vending_machine_param dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .c1      (c1),
    .c2      (c2),
    .cnl     (cnl),
    .rs_vld  (rs_vld),
    .rs_item (rs_item),
    .rs_qty  (rs_qty),
    .pdt     (pdt),
    .pdt_item(pdt_item),
    .cng     (cng),
    .rtn     (rtn),
    .rej     (rej),
    .err     (err),
    .sold_out(sold_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic take(input int kind, input int a, input int b);
    ev_t e;
    n_checks++;
    if (q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d expected none", kind, a, b);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b) begin
        n_errors++;
        $display("FAIL event: got kind=%0d a=%0d b=%0d expected kind=%0d a=%0d b=%0d",
                 kind, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  always @(negedge clk) begin
    if (pdt)       take(EV_PDT, int'(pdt_item), int'(cng));
    if (rtn != '0) take(EV_RTN, int'(rtn), 0);
    if (err)       take(EV_ERR, 0, 0);
    if (rej != '0) take(EV_REJ, int'(rej), 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int a, input int b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    q.push_back(e);
  endtask

  task automatic select(input int i);
    sel = N'(1) << i;
    tick();
    sel = '0;
    tick();
  endtask

  task automatic coin(input logic a, input logic b);
    c1 = a;
    c2 = b;
    tick();
    c1 = 1'b0;
    c2 = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk(name, q.size(), 0);
    q.delete();
  endtask

  task automatic chk_stock(input string name, input int i, input int exp);
    chk(name, int'(dut.u_stock.r_stock[i]), exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_pdt"}, int'(pdt), 0);
    chk({tag, "_rtn"}, int'(rtn), 0);
    chk({tag, "_rej"}, int'(rej), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_sold_out"}, int'(sold_out), 0);
    for (int i = 0; i < N; i++) chk_stock({tag, "_stock"}, i, 5);
  endtask

  initial begin
    rst = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");
    rst = 1'b1;
    tick();

    // item 0 (price 3): 2+2 -> change 1
    push(EV_PDT, 0, 1);
    select(0);
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    tick();
    drain("vend0_drain");
    chk_stock("vend0_stock", 0, 4);
    chk("vend0_busy", int'(busy), 0);

    // item 3 (price 6): credit 4, cancel with c2 -> refund 6
    push(EV_RTN, 6, 0);
    select(3);
    coin(1'b1, 1'b0);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    cnl = 1'b1;
    c2  = 1'b1;
    tick();
    cnl = 1'b0;
    c2  = 1'b0;
    tick();
    drain("cancel_drain");
    chk_stock("cancel_stock3", 3, 5);

    // item 1 (price 4): one coin then timeout after 16 idle PAY cycles
    push(EV_RTN, 1, 0);
    select(1);
    coin(1'b1, 1'b0);
    repeat (15) tick();
    chk("timeout_early_rtn", int'(rtn), 0);
    chk("timeout_early_busy", int'(busy), 1);
    tick();
    chk("timeout_rtn", int'(rtn), 1);
    chk("timeout_refund_busy", int'(busy), 1);
    tick();
    chk("timeout_busy_clear", int'(busy), 0);
    drain("timeout_drain");

    // item 2 (price 5) five times until sold out
    for (int k = 0; k < 5; k++) begin
      push(EV_PDT, 2, 0);
      select(2);
      coin(1'b0, 1'b1);
      coin(1'b0, 1'b1);
      coin(1'b1, 1'b0);
      tick();
    end
    drain("soldout_drain");
    chk("soldout_bit2", int'(sold_out[2]), 1);
    chk_stock("soldout_stock2", 2, 0);
    push(EV_ERR, 0, 0);
    select(2);
    chk("soldout_err_busy", int'(busy), 0);
    drain("soldout_err_drain");

    rs_vld  = 1'b1;
    rs_item = 2'd2;
    rs_qty  = 4'd15;
    tick();
    rs_vld = 1'b0;
    chk_stock("restock_stock2", 2, 15);
    chk("restock_bit2", int'(sold_out[2]), 0);
    rs_vld = 1'b1;
    tick();
    rs_vld = 1'b0;
    chk_stock("restock_saturate", 2, 15);

    // coin in IDLE is rejected; then c1+c2 together buys item 0 with restock in VEND cycle
    push(EV_REJ, 2, 0);
    coin(1'b0, 1'b1);
    tick();
    drain("reject_drain");
    push(EV_PDT, 0, 0);
    select(0);
    coin(1'b1, 1'b1);
    rs_vld  = 1'b1;
    rs_item = 2'd0;
    rs_qty  = 4'd3;
    tick();
    rs_vld = 1'b0;
    drain("dual_coin_drain");
    chk_stock("vend_restock_stock0", 0, 6);

    // reset in PAY with credit 3 discards it silently
    select(1);
    coin(1'b1, 1'b0);
    coin(1'b0, 1'b1);
    chk("prereset_busy", int'(busy), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_idle_outputs("midpay_reset");
    repeat (4) tick();
    chk("midpay_no_events", q.size(), 0);
    chk("midpay_still_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
